// File: rtl/stream_mux_nx1_pkg.sv
// Shared types and helpers for the N:1 streaming multiplexer.
package mux_pkg;
    typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/stream_mux_nx1_if.sv
// Handshake bundle between N producers, the mux and one consumer.
interface stream_mux_nx1_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = mux_pkg::clog2_min1(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, out_sel);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, out_sel);
endinterface

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// One-hot grant: rotate requests so the pointer sits at bit 0, take the
// lowest set bit, rotate back. Fixed mode is the same path with pointer 0.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int        N    = 4,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       SW   = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);
    logic [SW-1:0]  base;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt2;

    always_comb begin
        base    = (MODE == ARB_FIXED) ? '0 : ptr_i;
        rot_req = N'({req_i, req_i} >> base);
        rot_gnt = rot_req & (~rot_req + N'(1));
        gnt2    = {rot_gnt, rot_gnt} << base;
        gnt_o   = gnt2[2*N-1:N];
    end
endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 valid/ready stream mux with one registered output stage and
// round-robin or fixed-priority arbitration.
module stream_mux_nx1
    import mux_pkg::*;
#(
    parameter int        N    = 4,
    parameter int        W    = 8,
    parameter arb_mode_e MODE = ARB_RR
) (
    input  logic             clk,
    input  logic             rst,
    stream_mux_nx1_if.slave  bus
);
    localparam int SW = clog2_min1(N);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("stream_mux_nx1: N=%0d outside 2..16", N);
    end
    if (W < 1) begin : g_bad_w
        $error("stream_mux_nx1: W must be >= 1");
    end

    logic [N-1:0]  gnt;
    logic [SW-1:0] gidx;
    logic [W-1:0]  gdata;
    logic          load;
    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
        .req_i (bus.in_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    // AND-OR select keyed on the grant keeps ungranted data out of the stage.
    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gidx = SW'(i);
            gdata = gdata | (bus.in_data[i*W +: W] & {W{gnt[i]}});
        end
    end

    assign load         = !valid_q || bus.out_ready;
    assign bus.in_ready = rst ? '0 : (gnt & {N{load}});

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = |gnt;
            if (|gnt) begin
                data_d = gdata;
                sel_d  = gidx;
                if (MODE == ARB_RR)
                    ptr_d = (gidx == SW'(N-1)) ? '0 : gidx + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed and randomized checks of stream_mux_nx1 in RR, fixed and N=3 forms.
module tb_stream_mux_nx1;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stream_mux_nx1_if #(.N(4), .W(8)) rr_if ();
    stream_mux_nx1_if #(.N(4), .W(8)) fx_if ();
    stream_mux_nx1_if #(.N(3), .W(5)) st_if ();

    stream_mux_nx1 #(.N(4), .W(8), .MODE(ARB_RR))    dut_rr (.clk(clk), .rst(rst), .bus(rr_if.slave));
    stream_mux_nx1 #(.N(4), .W(8), .MODE(ARB_FIXED)) dut_fx (.clk(clk), .rst(rst), .bus(fx_if.slave));
    stream_mux_nx1 #(.N(3), .W(5), .MODE(ARB_RR))    dut_st (.clk(clk), .rst(rst), .bus(st_if.slave));

    // Producer-side protocol and grant shape on the stress instance.
    logic [2:0]  pv, pr;
    logic [14:0] pd;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (!rst && pv[i] && !pr[i])
                assert (st_if.in_valid[i] && st_if.in_data[i*5 +: 5] == pd[i*5 +: 5])
                    else $error("producer %0d dropped or changed a pending word", i);
        assert ($onehot0(st_if.in_ready)) else $error("in_ready not one-hot");
        pv <= rst ? 3'b000 : st_if.in_valid;
        pr <= st_if.in_ready;
        pd <= st_if.in_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rr_if.in_data = {8'h33, 8'h22, 8'h11, 8'h00};
        rr_if.in_valid = 4'hF;
        rr_if.out_ready = 1'b1;
        fx_if.in_data = {8'h33, 8'h22, 8'h11, 8'h00};
        fx_if.in_valid = 4'h0;
        fx_if.out_ready = 1'b0;
        st_if.in_data = '0;
        st_if.in_valid = '0;
        st_if.out_ready = 1'b0;
        #2;
        checks++; if (rr_if.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%0b exp=0", rr_if.out_valid); end
        checks++; if (rr_if.out_data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h exp=00", rr_if.out_data); end
        checks++; if (rr_if.out_sel !== 2'd0) begin errs++; $display("FAIL reset_sel got=%0d exp=0", rr_if.out_sel); end
        checks++; if (rr_if.in_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got=%b exp=0000", rr_if.in_ready); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rr_fairness();
        logic [3:0] er;
        logic [7:0] ed;
        for (int k = 0; k < 6; k++) begin
            er = 4'b0001 << (k % 4);
            ed = 8'((k % 4) * 17);
            #1;
            checks++; if (rr_if.in_ready !== er) begin errs++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, rr_if.in_ready, er); end
            tick();
            checks++;
            if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== ed || rr_if.out_sel !== 2'(k % 4)) begin
                errs++; $display("FAIL rr_out k=%0d got v=%0b d=%h s=%0d exp v=1 d=%h s=%0d",
                                 k, rr_if.out_valid, rr_if.out_data, rr_if.out_sel, ed, k % 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        checks++;
        if (rr_if.out_valid !== 1'b0 || rr_if.out_data !== 8'h00 || rr_if.out_sel !== 2'd0 || rr_if.in_ready !== 4'b0000) begin
            errs++; $display("FAIL mid_reset got v=%0b d=%h s=%0d r=%b exp v=0 d=00 s=0 r=0000",
                             rr_if.out_valid, rr_if.out_data, rr_if.out_sel, rr_if.in_ready);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (rr_if.in_ready !== 4'b0001) begin errs++; $display("FAIL post_reset_ready got=%b exp=0001", rr_if.in_ready); end
        tick();
        checks++;
        if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 8'h00 || rr_if.out_sel !== 2'd0) begin
            errs++; $display("FAIL post_reset_out got v=%0b d=%h s=%0d exp v=1 d=00 s=0", rr_if.out_valid, rr_if.out_data, rr_if.out_sel);
        end
    endtask

    task automatic test_backpressure();
        tick();
        tick();
        checks++; if (rr_if.out_data !== 8'h22) begin errs++; $display("FAIL bp_preload got=%h exp=22", rr_if.out_data); end
        rr_if.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rr_if.in_ready !== 4'b0000) begin errs++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, rr_if.in_ready); end
            tick();
            checks++;
            if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 8'h22 || rr_if.out_sel !== 2'd2) begin
                errs++; $display("FAIL bp_hold k=%0d got v=%0b d=%h s=%0d exp v=1 d=22 s=2", k, rr_if.out_valid, rr_if.out_data, rr_if.out_sel);
            end
        end
        rr_if.out_ready = 1'b1;
        #1;
        checks++; if (rr_if.in_ready !== 4'b1000) begin errs++; $display("FAIL bp_release_ready got=%b exp=1000", rr_if.in_ready); end
        tick();
        checks++;
        if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 8'h33 || rr_if.out_sel !== 2'd3) begin
            errs++; $display("FAIL bp_no_bubble got v=%0b d=%h s=%0d exp v=1 d=33 s=3", rr_if.out_valid, rr_if.out_data, rr_if.out_sel);
        end
    endtask

    task automatic test_sparse_wrap();
        rr_if.in_valid = 4'b0100;
        #1;
        checks++; if (rr_if.in_ready !== 4'b0100) begin errs++; $display("FAIL sp_ch2_ready got=%b exp=0100", rr_if.in_ready); end
        tick();
        rr_if.in_valid = 4'b0001;
        #1;
        checks++; if (rr_if.in_ready !== 4'b0001) begin errs++; $display("FAIL sp_wrap_ready got=%b exp=0001", rr_if.in_ready); end
        tick();
        checks++;
        if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 8'h00 || rr_if.out_sel !== 2'd0) begin
            errs++; $display("FAIL sp_wrap_out got v=%0b d=%h s=%0d exp v=1 d=00 s=0", rr_if.out_valid, rr_if.out_data, rr_if.out_sel);
        end
        rr_if.in_valid = 4'b0000;
        #1;
        checks++; if (rr_if.in_ready !== 4'b0000) begin errs++; $display("FAIL sp_idle_ready got=%b exp=0000", rr_if.in_ready); end
        tick();
        checks++;
        if (rr_if.out_valid !== 1'b0 || rr_if.out_data !== 8'h00 || rr_if.out_sel !== 2'd0) begin
            errs++; $display("FAIL sp_drain got v=%0b d=%h s=%0d exp v=0 d=00 s=0", rr_if.out_valid, rr_if.out_data, rr_if.out_sel);
        end
        tick();
        checks++; if (rr_if.out_valid !== 1'b0) begin errs++; $display("FAIL sp_idle2 got v=%0b exp=0", rr_if.out_valid); end
        rr_if.in_valid = 4'hF;
        #1;
        checks++; if (rr_if.in_ready !== 4'b0010) begin errs++; $display("FAIL sp_ptr_kept got=%b exp=0010", rr_if.in_ready); end
        tick();
        checks++;
        if (rr_if.out_data !== 8'h11 || rr_if.out_sel !== 2'd1) begin
            errs++; $display("FAIL sp_resume got d=%h s=%0d exp d=11 s=1", rr_if.out_data, rr_if.out_sel);
        end
        rr_if.in_valid = 4'h0;
        tick();
    endtask

    task automatic test_fixed();
        fx_if.in_valid = 4'b1010;
        fx_if.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (fx_if.in_ready !== 4'b0010) begin errs++; $display("FAIL fx_ready k=%0d got=%b exp=0010", k, fx_if.in_ready); end
            tick();
            checks++;
            if (fx_if.out_valid !== 1'b1 || fx_if.out_data !== 8'h11 || fx_if.out_sel !== 2'd1) begin
                errs++; $display("FAIL fx_out k=%0d got v=%0b d=%h s=%0d exp v=1 d=11 s=1", k, fx_if.out_valid, fx_if.out_data, fx_if.out_sel);
            end
        end
        fx_if.in_valid = 4'b1000;
        #1;
        checks++; if (fx_if.in_ready !== 4'b1000) begin errs++; $display("FAIL fx_ch3_ready got=%b exp=1000", fx_if.in_ready); end
        tick();
        checks++;
        if (fx_if.out_data !== 8'h33 || fx_if.out_sel !== 2'd3) begin
            errs++; $display("FAIL fx_ch3_out got d=%h s=%0d exp d=33 s=3", fx_if.out_data, fx_if.out_sel);
        end
        fx_if.in_valid = 4'b1010;
        tick();
        fx_if.in_valid = 4'b1001;
        #1;
        checks++; if (fx_if.in_ready !== 4'b0001) begin errs++; $display("FAIL fx_no_rotate got=%b exp=0001", fx_if.in_ready); end
        tick();
        checks++;
        if (fx_if.out_data !== 8'h00 || fx_if.out_sel !== 2'd0) begin
            errs++; $display("FAIL fx_ch0_out got d=%h s=%0d exp d=00 s=0", fx_if.out_data, fx_if.out_sel);
        end
        fx_if.in_valid = 4'h0;
        tick();
    endtask

    task automatic test_stress();
        logic [2:0] v, acc, rdy;
        logic [4:0] ed;
        logic [1:0] c;
        logic       ld;
        int push[3], pop[3];
        for (int i = 0; i < 3; i++) begin push[i] = 0; pop[i] = 0; end
        v = '0; acc = '0;
        for (int cyc = 0; cyc < 1020; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] || acc[i]) begin
                    v[i] = (cyc < 1000) && ($urandom_range(0, 99) < 60);
                    st_if.in_data[i*5 +: 5] = {i[1:0], 3'(push[i])};
                end
            end
            st_if.in_valid = v;
            st_if.out_ready = (cyc >= 1000) ? 1'b1 : ($urandom_range(0, 99) < 70);
            #1;
            rdy = st_if.in_ready;
            ld = !st_if.out_valid || st_if.out_ready;
            checks++;
            if (!$onehot0(rdy) || (rdy & ~v) != 3'b000 || (|rdy) !== (ld && |v)) begin
                errs++; $display("FAIL st_ready cyc=%0d got=%b valid=%b load=%0b", cyc, rdy, v, ld);
            end
            if (st_if.out_valid && st_if.out_ready) begin
                c = st_if.out_sel;
                checks++;
                if (c > 2'd2) begin
                    errs++; $display("FAIL st_sel cyc=%0d got=%0d exp<3", cyc, c);
                end else begin
                    ed = {c, 3'(pop[c])};
                    if (st_if.out_data !== ed) begin
                        errs++; $display("FAIL st_order cyc=%0d ch=%0d got=%h exp=%h", cyc, c, st_if.out_data, ed);
                    end
                    pop[c]++;
                end
            end
            acc = v & rdy;
            for (int i = 0; i < 3; i++) if (acc[i]) push[i]++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (push[i] != pop[i]) begin errs++; $display("FAIL st_count ch=%0d popped=%0d pushed=%0d", i, pop[i], push[i]); end
        end
        checks++; if (st_if.out_valid !== 1'b0) begin errs++; $display("FAIL st_final_valid got=%0b exp=0", st_if.out_valid); end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_reset_mid();
        test_backpressure();
        test_sparse_wrap();
        test_fixed();
        test_stress();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
